controlador_fetch: RTL and testbench

Instruction-fetch controller sitting between the program counter logic and `InstructionMemory`. It arbitrates the memory's single address port between a boot-time program loader (writes) and the fetch path (reads). It sequences the PC and delivers fetched instructions to decode through a one-entry valid/ready output register. It also handles branch redirects and stops fetching on a halt instruction.

---
 rtl/pkg_fetch.sv | 21 ++
 rtl/registro_salida.sv | 65 ++++++
 rtl/controlador_fetch.sv | 126 ++++++++++++
 tb/tb_controlador_fetch.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pkg_fetch.sv
// rtl/pkg_fetch.sv - shared types and constants for the instruction-fetch controller
//
// Purpose: FSM state encoding, halt opcode, pc step and the redirect
//          alignment helper used by controlador_fetch.
package pkg_fetch;

    typedef enum logic [1:0] {
        CARGA    = 2'd0,
        BUSQUEDA = 2'd1,
        ALTO     = 2'd2
    } estado_t;

    localparam logic [31:0] HLT_CODE = 32'hD4400000;
    localparam logic [63:0] PC_PASO  = 64'd4;

    // Redirect targets are byte addresses; instructions are word aligned.
    function automatic logic [63:0] alinear(input logic [63:0] dir);
        return dir & ~64'd3;
    endfunction

endpackage

// File: rtl/registro_salida.sv
// rtl/registro_salida.sv - one-entry instruction/pc output register with valid/ready
//
// Purpose: holds the instruction presented to decode together with its pc.
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   cargar            capture dato_in/pc_in and mark the entry valid
//   vaciar            drop the entry (wins over cargar)
//   listo             decode accepts the entry this cycle
//   dato_in, pc_in    instruction word and its byte address to capture
//   valida            entry holds a valid instruction
//   instruccion       presented instruction
//   pc_inst           byte address of the presented instruction
//   libre             entry can take a new word this cycle (empty or draining)
import pkg_fetch::*;

module registro_salida (
    input  logic        clk,
    input  logic        reset,
    input  logic        cargar,
    input  logic        vaciar,
    input  logic        listo,
    input  logic [31:0] dato_in,
    input  logic [63:0] pc_in,
    output logic        valida,
    output logic [31:0] instruccion,
    output logic [63:0] pc_inst,
    output logic        libre
);

    logic        valida_q, valida_d;
    logic [31:0] instruccion_q, instruccion_d;
    logic [63:0] pc_inst_q, pc_inst_d;

    always_comb begin
        valida_d      = valida_q;
        instruccion_d = instruccion_q;
        pc_inst_d     = pc_inst_q;
        if (vaciar) begin
            valida_d = 1'b0;
        end else if (cargar) begin
            valida_d      = 1'b1;
            instruccion_d = dato_in;
            pc_inst_d     = pc_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valida_q      <= 1'b0;
            instruccion_q <= 32'd0;
            pc_inst_q     <= 64'd0;
        end else begin
            valida_q      <= valida_d;
            instruccion_q <= instruccion_d;
            pc_inst_q     <= pc_inst_d;
        end
    end

    assign valida      = valida_q;
    assign instruccion = instruccion_q;
    assign pc_inst     = pc_inst_q;
    // A handshake this cycle frees the slot for the word read now.
    assign libre       = !valida_q || listo;

endmodule

// File: rtl/controlador_fetch.sv
// rtl/controlador_fetch.sv - instruction-fetch controller with boot loader port
//
// Purpose: shares the InstructionMemory address port between the boot loader
//          (CARGA) and the fetch path (BUSQUEDA), sequences the pc, handles
//          redirects and stops on the halt opcode (ALTO).
// Ports:
//   clk, reset                               clock, asynchronous active-high reset
//   inicio                                   CARGA->BUSQUEDA, ALTO->CARGA
//   carga_valida/carga_dir/carga_dato        loader write request
//   carga_listo                              loader write accepted
//   mem_dir/mem_escritura/mem_dato           memory address, write enable, write data
//   mem_instruccion                          combinational memory read data
//   salto/destino_salto                      redirect request and byte target
//   inst_valida/inst_listo/instruccion/pc_inst  output to decode
//   estado                                   current FSM state
import pkg_fetch::*;

module controlador_fetch #(
    parameter int          ANCHO_IDX  = 8,
    parameter logic [63:0] PC_INICIAL = 64'h0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 inicio,
    input  logic                 carga_valida,
    input  logic [ANCHO_IDX-1:0] carga_dir,
    input  logic [31:0]          carga_dato,
    output logic                 carga_listo,
    output logic [ANCHO_IDX-1:0] mem_dir,
    output logic                 mem_escritura,
    output logic [31:0]          mem_dato,
    input  logic [31:0]          mem_instruccion,
    input  logic                 salto,
    input  logic [63:0]          destino_salto,
    output logic                 inst_valida,
    input  logic                 inst_listo,
    output logic [31:0]          instruccion,
    output logic [63:0]          pc_inst,
    output logic [1:0]           estado
);

    estado_t     estado_q, estado_d;
    logic [63:0] pc_q, pc_d;

    logic cargar;
    logic vaciar;
    logic libre;

    registro_salida u_registro_salida (
        .clk         (clk),
        .reset       (reset),
        .cargar      (cargar),
        .vaciar      (vaciar),
        .listo       (inst_listo),
        .dato_in     (mem_instruccion),
        .pc_in       (pc_q),
        .valida      (inst_valida),
        .instruccion (instruccion),
        .pc_inst     (pc_inst),
        .libre       (libre)
    );

    always_comb begin
        estado_d      = estado_q;
        pc_d          = pc_q;
        carga_listo   = 1'b0;
        mem_escritura = 1'b0;
        mem_dato      = 32'd0;
        // Word index of the pc; upper bits are dropped so fetches wrap the memory.
        mem_dir       = pc_q[ANCHO_IDX+1:2];
        cargar        = 1'b0;
        vaciar        = 1'b0;

        case (estado_q)
            CARGA: begin
                carga_listo   = 1'b1;
                mem_dir       = carga_dir;
                mem_dato      = carga_dato;
                mem_escritura = carga_valida;
                vaciar        = 1'b1;
                if (inicio) begin
                    estado_d = BUSQUEDA;
                    pc_d     = PC_INICIAL;
                end
            end
            BUSQUEDA: begin
                if (salto) begin
                    // Redirect beats a pending handshake: the held word is dropped.
                    vaciar = 1'b1;
                    pc_d   = alinear(destino_salto);
                end else if (libre) begin
                    pc_d = pc_q + PC_PASO;
                    if (mem_instruccion == HLT_CODE) begin
                        vaciar   = 1'b1;
                        estado_d = ALTO;
                    end else begin
                        cargar = 1'b1;
                    end
                end
            end
            ALTO: begin
                vaciar = 1'b1;
                if (inicio) begin
                    estado_d = CARGA;
                end
            end
            default: begin
                vaciar   = 1'b1;
                estado_d = CARGA;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado_q <= CARGA;
            pc_q     <= PC_INICIAL;
        end else begin
            estado_q <= estado_d;
            pc_q     <= pc_d;
        end
    end

    assign estado = estado_q;

endmodule

// File: tb/tb_controlador_fetch.sv
// tb/tb_controlador_fetch.sv - self-checking bench for controlador_fetch
module tb_controlador_fetch;

    localparam int          AI  = 8;
    localparam logic [31:0] HLT = 32'hD4400000;

    logic          clk = 1'b0;
    logic          reset;
    logic          inicio;
    logic          carga_valida;
    logic [AI-1:0] carga_dir;
    logic [31:0]   carga_dato;
    logic          carga_listo;
    logic [AI-1:0] mem_dir;
    logic          mem_escritura;
    logic [31:0]   mem_dato;
    logic [31:0]   mem_instruccion;
    logic          salto;
    logic [63:0]   destino_salto;
    logic          inst_valida;
    logic          inst_listo;
    logic [31:0]   instruccion;
    logic [63:0]   pc_inst;
    logic [1:0]    estado;

    int total = 0;
    int bad   = 0;

    controlador_fetch #(.ANCHO_IDX(AI), .PC_INICIAL(64'h0)) dut (
        .clk             (clk),
        .reset           (reset),
        .inicio          (inicio),
        .carga_valida    (carga_valida),
        .carga_dir       (carga_dir),
        .carga_dato      (carga_dato),
        .carga_listo     (carga_listo),
        .mem_dir         (mem_dir),
        .mem_escritura   (mem_escritura),
        .mem_dato        (mem_dato),
        .mem_instruccion (mem_instruccion),
        .salto           (salto),
        .destino_salto   (destino_salto),
        .inst_valida     (inst_valida),
        .inst_listo      (inst_listo),
        .instruccion     (instruccion),
        .pc_inst         (pc_inst),
        .estado          (estado)
    );

    always #5 clk = ~clk;

    // InstructionMemory: combinational read, synchronous write.
    logic [31:0] mem [0:255] = '{default: 32'd0};
    assign mem_instruccion = mem[mem_dir];
    always @(posedge clk) if (mem_escritura) mem[mem_dir] <= mem_dato;

    // Behavioural reference model.
    int          m_estado;
    logic [63:0] m_pc;
    logic        m_valid;
    logic [31:0] m_inst;
    logic [63:0] m_pcinst;
    logic [31:0] model_mem [0:255] = '{default: 32'd0};

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_estado <= 0;
            m_pc     <= 64'd0;
            m_valid  <= 1'b0;
            m_inst   <= 32'd0;
            m_pcinst <= 64'd0;
        end else begin
            case (m_estado)
                0: begin
                    if (carga_valida) model_mem[carga_dir] <= carga_dato;
                    m_valid <= 1'b0;
                    if (inicio) begin
                        m_estado <= 1;
                        m_pc     <= 64'd0;
                    end
                end
                1: begin
                    if (salto) begin
                        m_pc    <= destino_salto - (destino_salto % 4);
                        m_valid <= 1'b0;
                    end else if (!m_valid || inst_listo) begin
                        m_pc <= m_pc + 64'd4;
                        if (model_mem[(m_pc >> 2) % 256] == HLT) begin
                            m_valid  <= 1'b0;
                            m_estado <= 2;
                        end else begin
                            m_valid  <= 1'b1;
                            m_inst   <= model_mem[(m_pc >> 2) % 256];
                            m_pcinst <= m_pc;
                        end
                    end
                end
                default: begin
                    m_valid <= 1'b0;
                    if (inicio) m_estado <= 0;
                end
            endcase
        end
    end

    task automatic chk(input string nombre, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nombre, act, exp, $time);
        end
    endtask

    // Compare process: every cycle, away from the active edge.
    always @(negedge clk) begin
        chk("estado", 64'(estado), 64'(m_estado));
        chk("inst_valida", 64'(inst_valida), 64'(m_valid));
        if (m_valid) begin
            chk("instruccion", 64'(instruccion), 64'(m_inst));
            chk("pc_inst", pc_inst, m_pcinst);
        end
        case (m_estado)
            0: begin
                chk("carga_listo", 64'(carga_listo), 64'd1);
                chk("mem_escritura", 64'(mem_escritura), 64'(carga_valida));
                chk("mem_dir_carga", 64'(mem_dir), 64'(carga_dir));
                chk("mem_dato", 64'(mem_dato), 64'(carga_dato));
            end
            1: begin
                chk("carga_listo", 64'(carga_listo), 64'd0);
                chk("mem_escritura", 64'(mem_escritura), 64'd0);
                chk("mem_dir_fetch", 64'(mem_dir), (m_pc >> 2) % 256);
            end
            default: begin
                chk("carga_listo", 64'(carga_listo), 64'd0);
                chk("mem_escritura", 64'(mem_escritura), 64'd0);
            end
        endcase
    end

    logic [31:0] w [0:255];

    function automatic logic [31:0] rnd_word();
        logic [31:0] x;
        x = $urandom;
        if (x == HLT) x = 32'h1;
        return x;
    endfunction

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int idx, input logic [31:0] dato);
        carga_valida = 1'b1;
        carga_dir    = AI'(idx);
        carga_dato   = dato;
        edge1();
        carga_valida = 1'b0;
    endtask

    task automatic wait_valid(input int budget);
        for (int i = 0; i < budget && !inst_valida; i++) edge1();
        chk("espera_valida", 64'(inst_valida), 64'd1);
    endtask

    initial begin
        int mism;
        reset = 1'b1; inicio = 1'b0; carga_valida = 1'b0; carga_dir = '0;
        carga_dato = '0; salto = 1'b0; destino_salto = '0; inst_listo = 1'b0;
        for (int i = 0; i < 256; i++) w[i] = rnd_word();
        w[0] = 32'h8B020020; w[1] = 32'hCB020020; w[2] = HLT;

        repeat (2) edge1();
        chk("rst_estado", 64'(estado), 64'd0);
        chk("rst_carga_listo", 64'(carga_listo), 64'd1);
        chk("rst_inst_valida", 64'(inst_valida), 64'd0);
        chk("rst_mem_escritura", 64'(mem_escritura), 64'd0);
        chk("rst_instruccion", 64'(instruccion), 64'd0);
        chk("rst_pc_inst", pc_inst, 64'd0);
        reset = 1'b0;
        edge1();

        // Load and run to halt.
        for (int i = 0; i < 3; i++) load(i, w[i]);
        inst_listo = 1'b1;
        inicio = 1'b1; edge1(); inicio = 1'b0;
        chk("arranque_no_valida", 64'(inst_valida), 64'd0);
        edge1();
        chk("run_v0", 64'(inst_valida), 64'd1);
        chk("run_pc0", pc_inst, 64'h0);
        chk("run_i0", 64'(instruccion), 64'h8B020020);
        edge1();
        chk("run_pc1", pc_inst, 64'h4);
        chk("run_i1", 64'(instruccion), 64'hCB020020);
        edge1();
        chk("alto_estado", 64'(estado), 64'd2);
        chk("alto_valida", 64'(inst_valida), 64'd0);

        // Back to CARGA, fill the rest; last write coincides with inicio.
        inicio = 1'b1; edge1(); inicio = 1'b0;
        chk("vuelta_carga", 64'(estado), 64'd0);
        w[2] = rnd_word();
        for (int i = 2; i < 255; i++) load(i, w[i]);
        carga_valida = 1'b1; carga_dir = 8'd255; carga_dato = w[255]; inicio = 1'b1;
        edge1();
        carga_valida = 1'b0; inicio = 1'b0;
        chk("mem255", 64'(mem[255]), 64'(w[255]));

        // Stall at pc_inst=4.
        inst_listo = 1'b1;
        wait_valid(5);
        edge1();
        chk("pre_stall_pc", pc_inst, 64'h4);
        inst_listo = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("stall_mem_dir", 64'(mem_dir), 64'd2);
            edge1();
            chk("stall_pc", pc_inst, 64'h4);
            chk("stall_inst", 64'(instruccion), 64'(w[1]));
            chk("stall_valida", 64'(inst_valida), 64'd1);
        end
        inst_listo = 1'b1;
        edge1();
        chk("resume_pc", pc_inst, 64'h8);
        chk("resume_inst", 64'(instruccion), 64'(w[2]));

        // Redirect during stall; held word dropped even with inst_listo=1.
        inst_listo = 1'b0;
        edge1();
        salto = 1'b1; destino_salto = 64'h13; inst_listo = 1'b1;
        edge1();
        salto = 1'b0;
        chk("salto_descarta", 64'(inst_valida), 64'd0);
        edge1();
        chk("salto_pc", pc_inst, 64'h10);
        chk("salto_inst", 64'(instruccion), 64'(w[4]));

        // Wrap of the word index.
        salto = 1'b1; destino_salto = 64'h3FC;
        edge1();
        salto = 1'b0;
        chk("wrap_dir255", 64'(mem_dir), 64'd255);
        edge1();
        chk("wrap_pc3fc", pc_inst, 64'h3FC);
        chk("wrap_i255", 64'(instruccion), 64'(w[255]));
        chk("wrap_dir0", 64'(mem_dir), 64'd0);
        edge1();
        chk("wrap_pc400", pc_inst, 64'h400);
        chk("wrap_i0", 64'(instruccion), 64'(w[0]));

        // Loader lockout.
        carga_valida = 1'b1; carga_dir = 8'd5; carga_dato = 32'h12345678;
        #1;
        chk("lock_listo", 64'(carga_listo), 64'd0);
        chk("lock_escr", 64'(mem_escritura), 64'd0);
        edge1();
        carga_valida = 1'b0;
        chk("lock_mem5", 64'(mem[5]), 64'(w[5]));

        // Randomized run.
        for (int c = 0; c < 1500; c++) begin
            inst_listo    = ($urandom_range(0, 9) < 7);
            salto         = ($urandom_range(0, 19) == 0);
            destino_salto = ($urandom_range(0, 3) == 0) ? {$urandom, $urandom}
                                                        : 64'($urandom_range(0, 2047));
            carga_valida  = $urandom_range(0, 1);
            carga_dir     = AI'($urandom);
            carga_dato    = $urandom;
            edge1();
        end
        salto = 1'b0; carga_valida = 1'b0;

        mism = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== w[i] || model_mem[i] !== w[i]) mism++;
        chk("memoria_intacta", 64'(mism), 64'd0);

        // Async reset while stalled.
        inst_listo = 1'b0;
        wait_valid(5);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("rst_async_valida", 64'(inst_valida), 64'd0);
        chk("rst_async_estado", 64'(estado), 64'd0);
        chk("rst_async_listo", 64'(carga_listo), 64'd1);
        edge1();
        reset = 1'b0;
        repeat (3) edge1();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
